pb_field_decoder: RTL and testbench

- Streaming hardware protobuf wire-format parser: consumes a serialized message one byte per cycle.
- Decodes each message key (field number, wire type) and its value; varint and fixed values are accumulated into a 64-bit result.
- For length-delimited fields it emits the length on the field interface, then forwards the payload bytes on a separate byte interface.
- Sits directly downstream of the byte-stream source (DMA/unpacker) and feeds per-field consumers; bit-exact with the team's software varint/key decode.

---
 rtl/pb_field_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_pb_field_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_field_decoder.sv
// Streaming protobuf wire-format field decoder.
// Takes one serialized message byte per cycle and decodes the key and value of each field.
// Varint and fixed values are presented as one field beat each.
// For a length-delimited field, the beat carries the length.
// The payload bytes then pass through combinationally on the pay_* interface.
module pb_field_decoder #(
  parameter int MAX_VARINT_BYTES = 10,
  parameter int FIELD_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               fld_valid,
  input  logic               fld_ready,
  output logic [FIELD_W-1:0] fld_num,
  output logic [2:0]         fld_wire,
  output logic [63:0]        fld_value,
  output logic               fld_msg_last,
  output logic               pay_valid,
  input  logic               pay_ready,
  output logic [7:0]         pay_data,
  output logic               pay_last,
  output logic               pay_msg_last,
  output logic               err_valid,
  output logic [2:0]         err_code
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] VARINT_LAST = CNT_W'(MAX_VARINT_BYTES - 1);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OVERLONG = 3'd1;
  localparam logic [2:0] ERR_WIRE     = 3'd2;
  localparam logic [2:0] ERR_TRUNC    = 3'd3;
  localparam logic [2:0] ERR_ZERO     = 3'd4;

  typedef enum logic [2:0] {
    S_KEY    = 3'd0,
    S_VARINT = 3'd1,
    S_FIX    = 3'd2,
    S_LEN    = 3'd3,
    S_EMIT   = 3'd4,
    S_PAY    = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  state_t             state_q;
  logic               live_q;        // low while in reset, so in_ready stays low
  logic [CNT_W-1:0]   cnt_q;         // byte index inside the current varint / fixed value
  logic [CNT_W-1:0]   fix_last_q;    // index of the final fixed byte (3 or 7)
  logic [63:0]        acc_q;         // partial varint / fixed accumulator
  logic [FIELD_W-1:0] fld_num_q;
  logic [2:0]         fld_wire_q;
  logic [63:0]        fld_value_q;
  logic               fld_msg_last_q;
  logic [63:0]        pay_cnt_q;     // payload bytes still to forward
  logic               err_valid_q;
  logic [2:0]         err_code_q;

  logic               accept;
  logic               more;
  logic               overlong;
  logic [CNT_W+2:0]   var_shift;
  logic [5:0]         fix_shift;
  logic [63:0]        var_acc_d;
  logic [63:0]        fix_acc_d;
  logic [FIELD_W-1:0] key_num_d;
  logic [2:0]         key_wire_d;
  logic               wire_bad;
  logic [2:0]         byte_err_d;

  // Accumulator candidates for the byte being presented this cycle
  always_comb begin
    accept     = in_valid & in_ready;
    more       = in_data[7];
    overlong   = in_data[7] && (cnt_q == VARINT_LAST);
    // 7*k, computed as 8k - k
    var_shift  = {cnt_q, 3'b000} - {3'b000, cnt_q};
    fix_shift  = {cnt_q[2:0], 3'b000};
    var_acc_d  = acc_q | ({57'd0, in_data[6:0]} << var_shift);
    fix_acc_d  = acc_q | ({56'd0, in_data} << fix_shift);
    key_num_d  = FIELD_W'(var_acc_d >> 3);
    key_wire_d = var_acc_d[2:0];
    wire_bad   = !((key_wire_d == 3'd0) || (key_wire_d == 3'd1) ||
                   (key_wire_d == 3'd2) || (key_wire_d == 3'd5));
  end

  // Error classification of the presented byte; order encodes priority 3 > 1 > 2 > 4
  always_comb begin
    byte_err_d = ERR_NONE;
    if (accept) begin
      case (state_q)
        S_KEY: begin
          if (in_last)        byte_err_d = ERR_TRUNC;
          else if (overlong)  byte_err_d = ERR_OVERLONG;
          else if (!more) begin
            if (wire_bad)                      byte_err_d = ERR_WIRE;
            else if (key_num_d == '0)          byte_err_d = ERR_ZERO;
          end
        end
        S_VARINT: begin
          if (in_last && more) byte_err_d = ERR_TRUNC;
          else if (overlong)   byte_err_d = ERR_OVERLONG;
        end
        S_FIX: begin
          if (in_last && (cnt_q != fix_last_q)) byte_err_d = ERR_TRUNC;
        end
        S_LEN: begin
          // A zero length may end the message; a nonzero length still owes payload
          if (in_last && (more || (var_acc_d != 64'd0))) byte_err_d = ERR_TRUNC;
          else if (overlong)                             byte_err_d = ERR_OVERLONG;
        end
        S_PAY: begin
          if (in_last && (pay_cnt_q != 64'd1)) byte_err_d = ERR_TRUNC;
        end
        default: byte_err_d = ERR_NONE;
      endcase
    end
  end

  // Main parser FSM with registered field/error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_KEY;
      live_q         <= 1'b0;
      cnt_q          <= '0;
      fix_last_q     <= '0;
      acc_q          <= 64'd0;
      fld_num_q      <= '0;
      fld_wire_q     <= 3'd0;
      fld_value_q    <= 64'd0;
      fld_msg_last_q <= 1'b0;
      pay_cnt_q      <= 64'd0;
      err_valid_q    <= 1'b0;
      err_code_q     <= 3'd0;
    end else begin
      live_q      <= 1'b1;
      err_valid_q <= 1'b0;
      if (byte_err_d != ERR_NONE) begin
        // Abandon the field; a byte carrying in_last already closed the message
        err_valid_q <= 1'b1;
        err_code_q  <= byte_err_d;
        acc_q       <= 64'd0;
        cnt_q       <= '0;
        state_q     <= in_last ? S_KEY : S_DRAIN;
      end else begin
        case (state_q)
          S_KEY: begin
            if (accept) begin
              if (more) begin
                acc_q <= var_acc_d;
                cnt_q <= cnt_q + 1'b1;
              end else begin
                fld_num_q  <= key_num_d;
                fld_wire_q <= key_wire_d;
                acc_q      <= 64'd0;
                cnt_q      <= '0;
                case (key_wire_d)
                  3'd0: state_q <= S_VARINT;
                  3'd1: begin
                    fix_last_q <= CNT_W'(7);
                    state_q    <= S_FIX;
                  end
                  3'd5: begin
                    fix_last_q <= CNT_W'(3);
                    state_q    <= S_FIX;
                  end
                  default: state_q <= S_LEN;
                endcase
              end
            end
          end
          S_VARINT, S_LEN: begin
            if (accept) begin
              if (more) begin
                acc_q <= var_acc_d;
                cnt_q <= cnt_q + 1'b1;
              end else begin
                fld_value_q    <= var_acc_d;
                fld_msg_last_q <= in_last;
                acc_q          <= 64'd0;
                cnt_q          <= '0;
                state_q        <= S_EMIT;
              end
            end
          end
          S_FIX: begin
            if (accept) begin
              if (cnt_q == fix_last_q) begin
                fld_value_q    <= fix_acc_d;
                fld_msg_last_q <= in_last;
                acc_q          <= 64'd0;
                cnt_q          <= '0;
                state_q        <= S_EMIT;
              end else begin
                acc_q <= fix_acc_d;
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          S_EMIT: begin
            if (fld_ready) begin
              if ((fld_wire_q == 3'd2) && (fld_value_q != 64'd0)) begin
                pay_cnt_q <= fld_value_q;
                state_q   <= S_PAY;
              end else begin
                state_q   <= S_KEY;
              end
            end
          end
          S_PAY: begin
            if (accept) begin
              pay_cnt_q <= pay_cnt_q - 64'd1;
              if (pay_cnt_q == 64'd1) state_q <= S_KEY;
            end
          end
          S_DRAIN: begin
            if (accept && in_last) state_q <= S_KEY;
          end
          default: state_q <= S_KEY;
        endcase
      end
    end
  end

  // Handshake and pass-through outputs derived from the registered state
  always_comb begin
    in_ready     = live_q && ((state_q == S_PAY) ? pay_ready : (state_q != S_EMIT));
    fld_valid    = (state_q == S_EMIT);
    fld_num      = fld_num_q;
    fld_wire     = fld_wire_q;
    fld_value    = fld_value_q;
    fld_msg_last = fld_msg_last_q;
    pay_valid    = (state_q == S_PAY) && in_valid;
    pay_data     = (state_q == S_PAY) ? in_data : 8'd0;
    pay_last     = (state_q == S_PAY) && (pay_cnt_q == 64'd1);
    pay_msg_last = (state_q == S_PAY) && in_last;
    err_valid    = err_valid_q;
    err_code     = err_code_q;
  end

endmodule

// File: tb/tb_pb_field_decoder.sv
// Directed self-checking bench for pb_field_decoder.
module tb_pb_field_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        fld_valid;
  logic        fld_ready = 1'b1;
  logic [31:0] fld_num;
  logic [2:0]  fld_wire;
  logic [63:0] fld_value;
  logic        fld_msg_last;
  logic        pay_valid;
  logic        pay_ready = 1'b1;
  logic [7:0]  pay_data;
  logic        pay_last;
  logic        pay_msg_last;
  logic        err_valid;
  logic [2:0]  err_code;

  typedef struct {
    logic [31:0] num;
    logic [2:0]  wtype;
    logic [63:0] value;
    logic        msg_last;
  } fld_t;

  fld_t       fld_q[$];
  logic [9:0] pay_q[$];   // {data, last, msg_last}
  logic [2:0] err_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  pb_field_decoder #(.MAX_VARINT_BYTES(10), .FIELD_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_num(fld_num), .fld_wire(fld_wire),
    .fld_value(fld_value), .fld_msg_last(fld_msg_last),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .pay_last(pay_last), .pay_msg_last(pay_msg_last),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Record every completed handshake and error pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (fld_valid && fld_ready) begin
        fld_t f;
        f.num = fld_num; f.wtype = fld_wire; f.value = fld_value; f.msg_last = fld_msg_last;
        fld_q.push_back(f);
      end
      if (pay_valid && pay_ready) pay_q.push_back({pay_data, pay_last, pay_msg_last});
      if (err_valid) err_q.push_back(err_code);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    fld_q.delete(); pay_q.delete(); err_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    in_valid = 1'b1; in_data = b; in_last = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: byte %02h never accepted, in_ready=%0b want 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
  endtask

  task automatic test_reset();
    idle(2);
    $display("txn reset: outputs during reset");
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (fld_valid !== 1'b0 || pay_valid !== 1'b0 || err_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valids: got fld=%0b pay=%0b err=%0b want 0", fld_valid, pay_valid, err_valid); end
    n_checks++; if (err_code !== 3'd0 || fld_value !== 64'd0 || fld_num !== 32'd0) begin n_fail++;
      $display("FAIL reset_regs: got code=%0d value=%0h num=%0d want 0", err_code, fld_value, fld_num); end
    rst = 1'b0;
    idle(1);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_varint();
    clear_logs();
    send_byte(8'h08, 0); send_byte(8'h96, 0); send_byte(8'h01, 1);
    idle(4);
    $display("txn varint: 08 96 01 -> %0d field beats", fld_q.size());
    n_checks++; if (fld_q.size() !== 1) begin n_fail++; $display("FAIL varint_count: got %0d want 1", fld_q.size()); end
    if (fld_q.size() == 1) begin
      n_checks++; if (fld_q[0].num !== 32'd1 || fld_q[0].wtype !== 3'd0) begin n_fail++;
        $display("FAIL varint_key: got num=%0d wire=%0d want 1/0", fld_q[0].num, fld_q[0].wtype); end
      n_checks++; if (fld_q[0].value !== 64'd150 || fld_q[0].msg_last !== 1'b1) begin n_fail++;
        $display("FAIL varint_value: got %0d last=%0b want 150/1", fld_q[0].value, fld_q[0].msg_last); end
    end
    n_checks++; if (err_q.size() !== 0) begin n_fail++; $display("FAIL varint_err: got %0d errors want 0", err_q.size()); end
  endtask

  task automatic test_len_payload();
    logic [9:0] exp_pay [3];
    exp_pay[0] = {8'h61, 1'b0, 1'b0};
    exp_pay[1] = {8'h62, 1'b0, 1'b0};
    exp_pay[2] = {8'h63, 1'b1, 1'b1};
    clear_logs();
    send_byte(8'h12, 0); send_byte(8'h03, 0);
    send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
    idle(4);
    $display("txn len: 12 03 61 62 63 -> %0d beats, %0d payload bytes", fld_q.size(), pay_q.size());
    n_checks++; if (fld_q.size() !== 1) begin n_fail++; $display("FAIL len_count: got %0d want 1", fld_q.size()); end
    if (fld_q.size() == 1) begin
      n_checks++; if (fld_q[0].num !== 32'd2 || fld_q[0].wtype !== 3'd2 || fld_q[0].value !== 64'd3 || fld_q[0].msg_last !== 1'b0) begin
        n_fail++; $display("FAIL len_beat: got num=%0d wire=%0d value=%0d last=%0b want 2/2/3/0",
                           fld_q[0].num, fld_q[0].wtype, fld_q[0].value, fld_q[0].msg_last); end
    end
    n_checks++; if (pay_q.size() !== 3) begin n_fail++; $display("FAIL pay_count: got %0d want 3", pay_q.size()); end
    if (pay_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (pay_q[i] !== exp_pay[i]) begin n_fail++;
          $display("FAIL pay_byte%0d: got %03h want %03h", i, pay_q[i], exp_pay[i]); end
      end
    end
    // Zero-length field closing the message: beat only, no payload, no error
    clear_logs();
    send_byte(8'h12, 0); send_byte(8'h00, 1);
    idle(4);
    $display("txn len0: 12 00 -> %0d beats, %0d payload bytes", fld_q.size(), pay_q.size());
    n_checks++; if (fld_q.size() !== 1 || pay_q.size() !== 0 || err_q.size() !== 0) begin n_fail++;
      $display("FAIL len0_counts: got beats=%0d pay=%0d err=%0d want 1/0/0", fld_q.size(), pay_q.size(), err_q.size()); end
    if (fld_q.size() == 1) begin
      n_checks++; if (fld_q[0].value !== 64'd0 || fld_q[0].msg_last !== 1'b1) begin n_fail++;
        $display("FAIL len0_beat: got value=%0d last=%0b want 0/1", fld_q[0].value, fld_q[0].msg_last); end
    end
  endtask

  task automatic test_fixed();
    clear_logs();
    send_byte(8'h0D, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'h19, 0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8));
    idle(4);
    $display("txn fixed: fixed32 + fixed64 -> %0d beats", fld_q.size());
    n_checks++; if (fld_q.size() !== 2) begin n_fail++; $display("FAIL fixed_count: got %0d want 2", fld_q.size()); end
    if (fld_q.size() == 2) begin
      n_checks++; if (fld_q[0].num !== 32'd1 || fld_q[0].wtype !== 3'd5 || fld_q[0].value !== 64'h12345678 || fld_q[0].msg_last !== 1'b0) begin
        n_fail++; $display("FAIL fixed32: got num=%0d wire=%0d value=%0h last=%0b want 1/5/12345678/0",
                           fld_q[0].num, fld_q[0].wtype, fld_q[0].value, fld_q[0].msg_last); end
      n_checks++; if (fld_q[1].num !== 32'd3 || fld_q[1].wtype !== 3'd1 || fld_q[1].value !== 64'h0807060504030201 || fld_q[1].msg_last !== 1'b1) begin
        n_fail++; $display("FAIL fixed64: got num=%0d wire=%0d value=%0h last=%0b want 3/1/0807060504030201/1",
                           fld_q[1].num, fld_q[1].wtype, fld_q[1].value, fld_q[1].msg_last); end
    end
  endtask

  task automatic test_overlong();
    clear_logs();
    send_byte(8'h08, 0);
    for (int i = 0; i < 10; i++) send_byte(8'hFF, 0);
    send_byte(8'h00, 1);
    send_byte(8'h08, 0); send_byte(8'h01, 1);
    idle(4);
    $display("txn overlong: 08 + 10xFF + 00, then 08 01 -> errors=%0d beats=%0d", err_q.size(), fld_q.size());
    n_checks++; if (err_q.size() !== 1) begin n_fail++; $display("FAIL overlong_err_count: got %0d want 1", err_q.size()); end
    if (err_q.size() == 1) begin
      n_checks++; if (err_q[0] !== 3'd1) begin n_fail++; $display("FAIL overlong_code: got %0d want 1", err_q[0]); end
    end
    n_checks++; if (fld_q.size() !== 1) begin n_fail++; $display("FAIL overlong_beats: got %0d want 1", fld_q.size()); end
    if (fld_q.size() == 1) begin
      n_checks++; if (fld_q[0].value !== 64'd1 || fld_q[0].num !== 32'd1) begin n_fail++;
        $display("FAIL overlong_recover: got num=%0d value=%0d want 1/1", fld_q[0].num, fld_q[0].value); end
    end
  endtask

  task automatic test_errors();
    logic [2:0] exp_err [3];
    exp_err[0] = 3'd3; exp_err[1] = 3'd2; exp_err[2] = 3'd4;
    clear_logs();
    send_byte(8'h08, 0); send_byte(8'h96, 1);   // truncated varint -> back to key
    idle(2);
    n_checks++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL trunc_code_held: got %0d want 3", err_code); end
    send_byte(8'h0B, 0); send_byte(8'h00, 1);   // wire type 3
    send_byte(8'h02, 0); send_byte(8'h00, 1);   // field number zero
    send_byte(8'h08, 0); send_byte(8'h01, 1);
    idle(4);
    $display("txn errors: trunc / bad wire / zero num -> errors=%0d beats=%0d", err_q.size(), fld_q.size());
    n_checks++; if (err_q.size() !== 3) begin n_fail++; $display("FAIL err_count: got %0d want 3", err_q.size()); end
    if (err_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (err_q[i] !== exp_err[i]) begin n_fail++;
          $display("FAIL err_code%0d: got %0d want %0d", i, err_q[i], exp_err[i]); end
      end
    end
    n_checks++; if (fld_q.size() !== 1) begin n_fail++; $display("FAIL err_beats: got %0d want 1", fld_q.size()); end
    if (fld_q.size() == 1) begin
      n_checks++; if (fld_q[0].value !== 64'd1) begin n_fail++; $display("FAIL err_recover: got %0d want 1", fld_q[0].value); end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    fld_ready = 1'b0;
    send_byte(8'h08, 0); send_byte(8'h96, 0); send_byte(8'h01, 1);
    in_valid = 1'b1; in_data = 8'h08; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (fld_valid !== 1'b1 || in_ready !== 1'b0 || fld_value !== 64'd150 || fld_num !== 32'd1) begin n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%0b in_ready=%0b value=%0d num=%0d want 1/0/150/1",
                 i, fld_valid, in_ready, fld_value, fld_num); end
      @(posedge clk); #1;
    end
    fld_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL handshake_in_ready: got %0b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || fld_valid !== 1'b0) begin n_fail++;
      $display("FAIL after_handshake: got in_ready=%0b fld_valid=%0b want 1/0", in_ready, fld_valid); end
    n_checks++; if (fld_q.size() !== 1) begin n_fail++; $display("FAIL hold_beats: got %0d want 1", fld_q.size()); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_byte(8'h01, 1);
    idle(4);
    $display("txn backpressure: 08 96 01 held 5 cycles then 08 01 -> %0d beats", fld_q.size());
    n_checks++; if (fld_q.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", fld_q.size()); end
    if (fld_q.size() == 2) begin
      n_checks++; if (fld_q[0].value !== 64'd150 || fld_q[1].value !== 64'd1) begin n_fail++;
        $display("FAIL bp_values: got %0d,%0d want 150,1", fld_q[0].value, fld_q[1].value); end
    end
  endtask

  task automatic test_reset_mid_field();
    clear_logs();
    send_byte(8'h08, 0); send_byte(8'h96, 0);
    rst = 1'b1;
    idle(2);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %0b want 0", in_ready); end
    rst = 1'b0;
    idle(1);
    send_byte(8'h08, 0); send_byte(8'h05, 1);
    idle(4);
    $display("txn reset_mid_field: 08 96 <rst> 08 05 -> %0d beats", fld_q.size());
    n_checks++; if (fld_q.size() !== 1) begin n_fail++; $display("FAIL midreset_count: got %0d want 1", fld_q.size()); end
    if (fld_q.size() == 1) begin
      n_checks++; if (fld_q[0].value !== 64'd5) begin n_fail++; $display("FAIL midreset_value: got %0d want 5", fld_q[0].value); end
    end
  endtask

  initial begin
    test_reset();
    test_varint();
    test_len_payload();
    test_fixed();
    test_overlong();
    test_errors();
    test_backpressure();
    test_reset_mid_field();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
